// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: turns hazard, taken-branch and
// data-memory wait requests into per-register freeze/flush controls plus perf counters.
module pipeline_stall_controller #(
  parameter int CNT_WIDTH    = 16,
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_MEM_WAIT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_Sig_Hazard_Detected,
  input  logic                 i_Sig_Branch_Taken,
  input  logic                 i_Sig_Mem_Request,
  input  logic                 i_Sig_Mem_Ready,
  input  logic                 i_Sig_Counter_Clear,
  output logic                 o_Sig_Freeze_PC,
  output logic                 o_Sig_Freeze_IF_ID,
  output logic                 o_Sig_Flush_IF_ID,
  output logic                 o_Sig_Freeze_ID_EX,
  output logic                 o_Sig_Flush_ID_EX,
  output logic                 o_Sig_Freeze_EX_MEM,
  output logic                 o_Sig_Bubble_MEM_WB,
  output logic                 o_Sig_Mem_Timeout,
  output logic [1:0]           o_State,
  output logic [CNT_WIDTH-1:0] o_Stall_Count,
  output logic [CNT_WIDTH-1:0] o_Flush_Count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_t;

  localparam logic [7:0]           MAX_WAIT_W     = 8'(MAX_MEM_WAIT);
  localparam logic [1:0]           FLUSH_REM_INIT = 2'(FLUSH_CYCLES - 1);
  localparam logic                 MULTI_FLUSH    = (FLUSH_CYCLES > 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX        = {CNT_WIDTH{1'b1}};

  state_t               state_q, state_d;
  logic [7:0]           wait_cnt_q, wait_cnt_d;
  logic [1:0]           flush_rem_q, flush_rem_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  logic memwait_s;
  logic freeze_pc_s, freeze_if_id_s, flush_if_id_s, freeze_id_ex_s;
  logic flush_id_ex_s, freeze_ex_mem_s, bubble_mem_wb_s, branch_acc_s;

  assign memwait_s = i_Sig_Mem_Request & ~i_Sig_Mem_Ready;

  // Control decode and next-state; RUN and the MEM_WAIT release share the branch/hazard rules.
  always_comb begin
    state_d         = state_q;
    wait_cnt_d      = wait_cnt_q;
    flush_rem_d     = flush_rem_q;
    timeout_d       = timeout_q;
    freeze_pc_s     = 1'b0;
    freeze_if_id_s  = 1'b0;
    flush_if_id_s   = 1'b0;
    freeze_id_ex_s  = 1'b0;
    flush_id_ex_s   = 1'b0;
    freeze_ex_mem_s = 1'b0;
    bubble_mem_wb_s = 1'b0;
    branch_acc_s    = 1'b0;

    case (state_q)
      ST_RUN, ST_FLUSH, ST_MEM_WAIT: begin
        if (memwait_s) begin
          freeze_pc_s     = 1'b1;
          freeze_if_id_s  = 1'b1;
          freeze_id_ex_s  = 1'b1;
          freeze_ex_mem_s = 1'b1;
          bubble_mem_wb_s = 1'b1;
          flush_rem_d     = 2'd0;
          wait_cnt_d      = (state_q == ST_MEM_WAIT) ? (wait_cnt_q + 8'd1) : 8'd1;
          if (wait_cnt_d >= MAX_WAIT_W) begin
            state_d   = ST_ERROR;
            timeout_d = 1'b1;
          end else begin
            state_d   = ST_MEM_WAIT;
          end
        end else if (state_q == ST_FLUSH) begin
          // Slots being flushed hold no valid work, so hazards are ignored here.
          flush_if_id_s = 1'b1;
          flush_id_ex_s = 1'b1;
          flush_rem_d   = flush_rem_q - 2'd1;
          state_d       = (flush_rem_q == 2'd1) ? ST_RUN : ST_FLUSH;
        end else if (i_Sig_Branch_Taken) begin
          flush_if_id_s = 1'b1;
          flush_id_ex_s = 1'b1;
          branch_acc_s  = 1'b1;
          wait_cnt_d    = 8'd0;
          flush_rem_d   = MULTI_FLUSH ? FLUSH_REM_INIT : 2'd0;
          state_d       = MULTI_FLUSH ? ST_FLUSH : ST_RUN;
        end else if (i_Sig_Hazard_Detected) begin
          freeze_pc_s    = 1'b1;
          freeze_if_id_s = 1'b1;
          flush_id_ex_s  = 1'b1;
          wait_cnt_d     = 8'd0;
          state_d        = ST_RUN;
        end else begin
          wait_cnt_d = 8'd0;
          state_d    = ST_RUN;
        end
      end
      ST_ERROR: begin
        freeze_pc_s     = 1'b1;
        freeze_if_id_s  = 1'b1;
        freeze_id_ex_s  = 1'b1;
        freeze_ex_mem_s = 1'b1;
        bubble_mem_wb_s = 1'b1;
        timeout_d       = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Saturating performance counters; clear beats increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (i_Sig_Counter_Clear) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (freeze_pc_s && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
      if (branch_acc_s && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_d = flush_cnt_q;
      end
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      flush_rem_q <= 2'd0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_rem_q <= flush_rem_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Every output is forced low while reset is held.
  assign o_Sig_Freeze_PC     = reset & freeze_pc_s;
  assign o_Sig_Freeze_IF_ID  = reset & freeze_if_id_s;
  assign o_Sig_Flush_IF_ID   = reset & flush_if_id_s;
  assign o_Sig_Freeze_ID_EX  = reset & freeze_id_ex_s;
  assign o_Sig_Flush_ID_EX   = reset & flush_id_ex_s;
  assign o_Sig_Freeze_EX_MEM = reset & freeze_ex_mem_s;
  assign o_Sig_Bubble_MEM_WB = reset & bubble_mem_wb_s;
  assign o_Sig_Mem_Timeout   = reset & timeout_q;
  assign o_State             = reset ? state_q : ST_RUN;
  assign o_Stall_Count       = {CNT_WIDTH{reset}} & stall_cnt_q;
  assign o_Flush_Count       = {CNT_WIDTH{reset}} & flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a rule-level model of the stall controller.
module tb_pipeline_stall_controller;
  localparam int CW = 2;
  localparam int FC = 2;
  localparam int MW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset, hz, br, req, rdy, clr;
  logic f_pc, f_ifid, fl_ifid, f_idex, fl_idex, f_exmem, b_memwb, tmo;
  logic [1:0] st;
  logic [CW-1:0] scnt, fcnt;

  int n_vec = 0;
  int n_bad = 0;

  // Model: progress of the current sequence in plain counts.
  int  m_wait, m_flush, m_stall, m_fcnt;
  bit  m_dead;
  // Expected outputs for the current cycle.
  int  e_fpc, e_fifid, e_flifid, e_fidex, e_flidex, e_fexmem, e_bub, e_tmo, e_st, e_sc, e_fc, e_acc;

  pipeline_stall_controller #(.CNT_WIDTH(CW), .FLUSH_CYCLES(FC), .MAX_MEM_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .i_Sig_Hazard_Detected(hz), .i_Sig_Branch_Taken(br),
    .i_Sig_Mem_Request(req), .i_Sig_Mem_Ready(rdy), .i_Sig_Counter_Clear(clr),
    .o_Sig_Freeze_PC(f_pc), .o_Sig_Freeze_IF_ID(f_ifid), .o_Sig_Flush_IF_ID(fl_ifid),
    .o_Sig_Freeze_ID_EX(f_idex), .o_Sig_Flush_ID_EX(fl_idex), .o_Sig_Freeze_EX_MEM(f_exmem),
    .o_Sig_Bubble_MEM_WB(b_memwb), .o_Sig_Mem_Timeout(tmo), .o_State(st),
    .o_Stall_Count(scnt), .o_Flush_Count(fcnt)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compute_exp();
    bit mw;
    {e_fpc, e_fifid, e_flifid, e_fidex, e_flidex, e_fexmem, e_bub} = '0;
    e_tmo = 0; e_st = 0; e_sc = 0; e_fc = 0; e_acc = 0;
    if (reset) begin
      mw = req && !rdy;
      e_st = m_dead ? 3 : (m_wait > 0) ? 2 : (m_flush > 0) ? 1 : 0;
      e_tmo = m_dead;
      e_sc = m_stall;
      e_fc = m_fcnt;
      if (m_dead || mw) begin
        e_fpc = 1; e_fifid = 1; e_fidex = 1; e_fexmem = 1; e_bub = 1;
      end else if (m_flush > 0) begin
        e_flifid = 1; e_flidex = 1;
      end else if (br) begin
        e_flifid = 1; e_flidex = 1; e_acc = 1;
      end else if (hz) begin
        e_fpc = 1; e_fifid = 1; e_flidex = 1;
      end
    end
  endtask

  task automatic model_update();
    bit mw;
    mw = req && !rdy;
    if (!reset) begin
      m_wait = 0; m_flush = 0; m_dead = 0; m_stall = 0; m_fcnt = 0;
    end else begin
      if (clr) begin
        m_stall = 0; m_fcnt = 0;
      end else begin
        if (e_fpc == 1) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        if (e_acc == 1) m_fcnt = (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
      end
      if (!m_dead) begin
        if (mw) begin
          m_flush = 0;
          m_wait++;
          if (m_wait >= MW) m_dead = 1;
        end else begin
          m_wait = 0;
          if (m_flush > 0) m_flush--;
          else if (br) m_flush = FC - 1;
        end
      end
    end
  endtask

  // One clock: compare every output at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    @(negedge clk);
    compute_exp();
    cmp("freeze_pc",     f_pc,    e_fpc);
    cmp("freeze_if_id",  f_ifid,  e_fifid);
    cmp("flush_if_id",   fl_ifid, e_flifid);
    cmp("freeze_id_ex",  f_idex,  e_fidex);
    cmp("flush_id_ex",   fl_idex, e_flidex);
    cmp("freeze_ex_mem", f_exmem, e_fexmem);
    cmp("bubble_mem_wb", b_memwb, e_bub);
    cmp("mem_timeout",   tmo,     e_tmo);
    cmp("state",         st,      e_st);
    cmp("stall_count",   scnt,    e_sc);
    cmp("flush_count",   fcnt,    e_fc);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input bit r, input bit h, input bit b, input bit q, input bit y, input bit c);
    reset = r; hz = h; br = b; req = q; rdy = y; clr = c;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  initial begin
    m_wait = 0; m_flush = 0; m_dead = 0; m_stall = 0; m_fcnt = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    // Hazard for two cycles.
    do_reset();
    hz = 1'b1; cycle(); cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    cmp("lit_hz_stall_count", scnt, 2);
    cmp("lit_hz_state", st, 0);

    // Branch together with hazard: flush only, two flush cycles.
    do_reset();
    br = 1'b1; hz = 1'b1;
    #1;
    cmp("lit_br_freeze_pc", f_pc, 0);
    cmp("lit_br_flush_if_id", fl_ifid, 1);
    cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    cmp("lit_br_state1", st, 1);
    cmp("lit_br_flush_id_ex2", fl_idex, 1);
    cmp("lit_br_freeze_pc2", f_pc, 0);
    cmp("lit_br_flush_count", fcnt, 1);
    cycle();
    hz = 1'b0; #1;
    cmp("lit_br_state0", st, 0);

    // Memory wait: ready low 3 cycles then high.
    do_reset();
    req = 1'b1; rdy = 1'b0;
    cycle(); cycle(); cycle();
    rdy = 1'b1; #1;
    cmp("lit_mw_state2", st, 2);
    cmp("lit_mw_release_freeze", f_pc, 0);
    cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    cmp("lit_mw_state0", st, 0);
    cmp("lit_mw_stall_count", scnt, 3);

    // Timeout after four wait cycles, sticky until reset.
    do_reset();
    req = 1'b1; rdy = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    cmp("lit_to_state3", st, 3);
    cmp("lit_to_flag", tmo, 1);
    cycle(); cycle();
    cmp("lit_to_sticky", tmo, 1);
    do_reset();
    #1;
    cmp("lit_to_cleared", tmo, 0);
    cmp("lit_to_state_run", st, 0);

    // Saturation, then clear beats a same-cycle stall.
    do_reset();
    hz = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    #1;
    cmp("lit_sat_stall_count", scnt, 3);
    clr = 1'b1; cycle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    cmp("lit_clear_wins", scnt, 0);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) >= 2);
      hz    = ($urandom_range(0, 99) < 25);
      br    = (m_flush == 0) && ($urandom_range(0, 99) < 15);
      req   = ($urandom_range(0, 99) < 35);
      rdy   = ($urandom_range(0, 99) < 55);
      clr   = ($urandom_range(0, 99) < 4);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
